// File: rtl/fft_out_reorder_32.sv
// Output reorder buffer for a 32-point SDF FFT: writes each frame at bit-reversed
// addresses into one of two banks and replays it in natural order.
module fft_out_reorder_32 #(
    parameter int WIDTH = 19,
    parameter int N     = 32,
    parameter int LOG2N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_i,
    output logic             out_last,
    output logic             frame_drop
);

    logic [2*WIDTH-1:0] mem [0:2*N-1];

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_last;
    logic             rd_active;
    logic             rd_last;
    logic             drop_d;

    logic             out_valid_q;
    logic             out_last_q;
    logic             frame_drop_q;
    logic [WIDTH-1:0] out_r_q;
    logic [WIDTH-1:0] out_i_q;

    // in_start restarts the frame at index 0 regardless of the running count
    assign wr_idx = in_start ? '0 : wr_cnt_q;

    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign wr_addr[gi] = wr_idx[LOG2N-1-gi];
        end
    endgenerate

    assign wr_last   = in_valid && (wr_idx == '1);
    // A bank stays full for the whole time it is being drained
    assign rd_active = full_q[rd_bank_q];
    assign rd_last   = rd_active && (rd_cnt_q == '1);

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        drop_d    = 1'b0;

        if (rd_active) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end

        // Set after clear so a fill on the same edge is never lost
        if (in_valid) begin
            drop_d   = in_start && (wr_cnt_q != '0);
            wr_cnt_d = wr_idx + 1'b1;
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[{wr_bank_q, wr_addr}] <= {in_r, in_i};
        end
    end

    // Registered read; data holds its last value while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            out_r_q      <= '0;
            out_i_q      <= '0;
        end else begin
            out_valid_q  <= rd_active;
            out_last_q   <= rd_last;
            frame_drop_q <= drop_d;
            if (rd_active) begin
                {out_r_q, out_i_q} <= mem[{rd_bank_q, rd_cnt_q}];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_drop = frame_drop_q;
    assign out_r      = out_r_q;
    assign out_i      = out_i_q;

endmodule

// File: tb/tb_fft_out_reorder_32.sv
// Bench for fft_out_reorder_32: drives bit-reversed frames and checks natural-order replay.
module tb_fft_out_reorder_32;

    localparam int W = 19;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_start = 1'b0;
    logic [W-1:0] in_r = '0;
    logic [W-1:0] in_i = '0;
    logic         out_valid;
    logic         out_last;
    logic         frame_drop;
    logic [W-1:0] out_r;
    logic [W-1:0] out_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mon_c;

    typedef struct {
        int           cyc;
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic         last;
    } samp_t;

    samp_t        cap[$];
    int           drop_cnt = 0;
    int           drop_cyc = -1;
    logic [W-1:0] nat_r[32];
    logic [W-1:0] nat_i[32];
    logic [W-1:0] exp_r[$];
    logic [W-1:0] exp_i[$];
    int           first_wr_edge;
    int           last_wr_edge;

    fft_out_reorder_32 #(.WIDTH(W), .N(32), .LOG2N(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_start   (in_start),
        .in_r       (in_r),
        .in_i       (in_i),
        .out_valid  (out_valid),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_last   (out_last),
        .frame_drop (frame_drop)
    );

    always #5 clk = ~clk;

    // Output monitor: one record per valid output cycle, tagged by edge number
    always @(posedge clk) begin
        cyc++;
        mon_c = cyc;
        #1;
        if (out_valid === 1'b1) cap.push_back('{mon_c, out_r, out_i, out_last});
        if (frame_drop === 1'b1) begin
            drop_cnt++;
            drop_cyc = mon_c;
        end
    end

    function automatic int br5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) if ((k >> b) & 1) r += 1 << (4 - b);
        return r;
    endfunction

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [W-1:0] r, input logic [W-1:0] i, input bit st);
        in_valid = 1'b1;
        in_r     = r;
        in_i     = i;
        in_start = st;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    // gap_mode: 0 none, 1 alternate, 2 random idle gaps
    task automatic drive_frame(input int gap_mode);
        for (int k = 0; k < 32; k++) begin
            drive_sample(nat_r[br5(k)], nat_i[br5(k)], k == 0);
            if (k == 0) first_wr_edge = cyc;
            if (k < 31) begin
                if (gap_mode == 1) idle_cycle();
                else if (gap_mode == 2) repeat ($urandom_range(0, 3)) idle_cycle();
            end
        end
        last_wr_edge = cyc;
        for (int n = 0; n < 32; n++) begin
            exp_r.push_back(nat_r[n]);
            exp_i.push_back(nat_i[n]);
        end
    endtask

    task automatic wait_drain(input int n);
        for (int t = 0; t < 400 && cap.size() < n; t++) idle_cycle();
        repeat (4) idle_cycle();
    endtask

    task automatic clear_all();
        cap.delete();
        exp_r.delete();
        exp_i.delete();
    endtask

    task automatic random_frame();
        for (int n = 0; n < 32; n++) begin
            nat_r[n] = W'($urandom);
            nat_i[n] = W'($urandom);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_drop !== 1'b0 ||
            out_r !== '0 || out_i !== '0)
            begin failures++; $display("FAIL reset_state: v=%b l=%b d=%b r=%0h i=%0h required all 0",
                                       out_valid, out_last, frame_drop, out_r, out_i); end
        repeat (3) idle_cycle();
        rst = 1'b0;
        repeat (3) idle_cycle();
        checks++;
        if (out_valid !== 1'b0 || out_r !== '0)
            begin failures++; $display("FAIL reset_idle: v=%b r=%0h required 0", out_valid, out_r); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        clear_all();
        for (int n = 0; n < 32; n++) begin
            nat_r[n] = W'(n);
            nat_i[n] = W'(-n);
        end
        drive_frame(0);
        wait_drain(32);
        checks++;
        if (cap.size() != 32)
            begin failures++; $display("FAIL single_count: got %0d samples required 32", cap.size()); end
        else begin
            checks++;
            if (cap[0].cyc != last_wr_edge + 1)
                begin failures++; $display("FAIL single_latency: first at edge %0d required %0d", cap[0].cyc, last_wr_edge + 1); end
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (cap[n].r !== exp_r[n] || cap[n].i !== exp_i[n] || cap[n].last !== (n == 31) ||
                    cap[n].cyc != cap[0].cyc + n)
                    begin failures++; $display("FAIL single_data[%0d]: r=%0h i=%0h last=%b required r=%0h i=%0h last=%b",
                                               n, cap[n].r, cap[n].i, cap[n].last, exp_r[n], exp_i[n], n == 31); end
            end
        end
        $display("test_single_frame done: %0d outputs", cap.size());
    endtask

    task automatic test_back_to_back();
        int f0_last;
        int lasts = 0;
        clear_all();
        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 32; n++) begin
                nat_r[n] = W'(100 * f + n);
                nat_i[n] = W'($urandom);
            end
            drive_frame(0);
            if (f == 0) f0_last = last_wr_edge;
        end
        wait_drain(128);
        checks++;
        if (cap.size() != 128)
            begin failures++; $display("FAIL b2b_count: got %0d samples required 128", cap.size()); end
        else begin
            checks++;
            if (cap[0].cyc != f0_last + 1)
                begin failures++; $display("FAIL b2b_latency: first at edge %0d required %0d", cap[0].cyc, f0_last + 1); end
            for (int n = 0; n < 128; n++) begin
                if (cap[n].last === 1'b1) lasts++;
                checks++;
                if (cap[n].r !== exp_r[n] || cap[n].i !== exp_i[n] || cap[n].last !== (n % 32 == 31) ||
                    cap[n].cyc != cap[0].cyc + n)
                    begin failures++; $display("FAIL b2b_data[%0d]: r=%0d i=%0h last=%b edge=%0d required r=%0d i=%0h last=%b edge=%0d",
                                               n, cap[n].r, cap[n].i, cap[n].last, cap[n].cyc, exp_r[n], exp_i[n], n % 32 == 31, cap[0].cyc + n); end
            end
            checks++;
            if (lasts != 4)
                begin failures++; $display("FAIL b2b_last_count: got %0d required 4", lasts); end
        end
        $display("test_back_to_back done: %0d outputs", cap.size());
    endtask

    task automatic test_gapped(input int gap_mode);
        clear_all();
        random_frame();
        drive_frame(gap_mode);
        wait_drain(32);
        checks++;
        if (cap.size() != 32)
            begin failures++; $display("FAIL gapped%0d_count: got %0d required 32", gap_mode, cap.size()); end
        else begin
            checks++;
            if (cap[0].cyc != last_wr_edge + 1)
                begin failures++; $display("FAIL gapped%0d_latency: first at edge %0d required %0d", gap_mode, cap[0].cyc, last_wr_edge + 1); end
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (cap[n].r !== exp_r[n] || cap[n].i !== exp_i[n] || cap[n].last !== (n == 31))
                    begin failures++; $display("FAIL gapped%0d_data[%0d]: r=%0h i=%0h required r=%0h i=%0h",
                                               gap_mode, n, cap[n].r, cap[n].i, exp_r[n], exp_i[n]); end
            end
        end
        $display("test_gapped mode %0d done: %0d outputs", gap_mode, cap.size());
    endtask

    task automatic test_drop();
        int drop_base;
        clear_all();
        drop_base = drop_cnt;
        for (int k = 0; k < 10; k++) drive_sample(W'($urandom), W'($urandom), k == 0);
        random_frame();
        drive_frame(0);
        wait_drain(32);
        checks++;
        if (drop_cnt - drop_base != 1 || drop_cyc != first_wr_edge)
            begin failures++; $display("FAIL drop_pulse: %0d cycles at edge %0d required 1 at edge %0d",
                                       drop_cnt - drop_base, drop_cyc, first_wr_edge); end
        checks++;
        if (cap.size() != 32)
            begin failures++; $display("FAIL drop_count: got %0d samples required 32", cap.size()); end
        else begin
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (cap[n].r !== exp_r[n] || cap[n].i !== exp_i[n])
                    begin failures++; $display("FAIL drop_data[%0d]: r=%0h i=%0h required r=%0h i=%0h",
                                               n, cap[n].r, cap[n].i, exp_r[n], exp_i[n]); end
            end
        end
        $display("test_drop done: %0d drop cycles", drop_cnt - drop_base);
    endtask

    task automatic test_reset_mid_read();
        bit found = 1'b0;
        clear_all();
        for (int n = 0; n < 32; n++) begin
            nat_r[n] = W'(n);
            nat_i[n] = W'($urandom);
        end
        drive_frame(0);
        for (int t = 0; t < 100 && !found; t++) begin
            if (out_valid === 1'b1 && out_r === W'(12)) found = 1'b1;
            else idle_cycle();
        end
        checks++;
        if (!found)
            begin failures++; $display("FAIL midrst_reach: out_r=12 not seen, last r=%0d required 12", out_r); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_r !== '0 || out_i !== '0)
            begin failures++; $display("FAIL midrst_async: v=%b l=%b r=%0h i=%0h required all 0",
                                       out_valid, out_last, out_r, out_i); end
        idle_cycle();
        rst = 1'b0;
        cap.delete();
        repeat (40) idle_cycle();
        checks++;
        if (cap.size() != 0 || out_valid !== 1'b0)
            begin failures++; $display("FAIL midrst_quiet: %0d outputs after reset required 0", cap.size()); end
        clear_all();
        random_frame();
        drive_frame(0);
        wait_drain(32);
        checks++;
        if (cap.size() != 32)
            begin failures++; $display("FAIL midrst_recover_count: got %0d required 32", cap.size()); end
        else begin
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (cap[n].r !== exp_r[n] || cap[n].i !== exp_i[n] || cap[n].last !== (n == 31))
                    begin failures++; $display("FAIL midrst_recover[%0d]: r=%0h i=%0h required r=%0h i=%0h",
                                               n, cap[n].r, cap[n].i, exp_r[n], exp_i[n]); end
            end
        end
        $display("test_reset_mid_read done");
    endtask

    task automatic test_extremes();
        clear_all();
        for (int n = 0; n < 32; n++) begin
            nat_r[n] = (n % 2 == 0) ? W'(262143) : W'(-262144);
            nat_i[n] = (n % 2 == 0) ? W'(-262144) : W'(262143);
        end
        drive_frame(0);
        wait_drain(32);
        checks++;
        if (cap.size() != 32)
            begin failures++; $display("FAIL extremes_count: got %0d required 32", cap.size()); end
        else begin
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (cap[n].r !== exp_r[n] || cap[n].i !== exp_i[n])
                    begin failures++; $display("FAIL extremes[%0d]: r=%0h i=%0h required r=%0h i=%0h",
                                               n, cap[n].r, cap[n].i, exp_r[n], exp_i[n]); end
            end
        end
        $display("test_extremes done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped(1);
        test_gapped(2);
        test_drop();
        test_reset_mid_read();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
